instruction_prefetch_unit: RTL

- Parametrised fetch stage that decouples instruction memory from decode.
- Holds the fetch PC and drives a synchronous-read instruction memory (1-cycle latency).
- Buffers fetched words, each tagged with its PC, in a QUEUE_DEPTH-entry FIFO.
- Presents them to decode through a valid/ready handshake; supports branch redirect with flush of queued and in-flight words.

---
 rtl/instruction_prefetch_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/instruction_prefetch_unit.sv
// rtl/instruction_prefetch_unit.sv - fetch stage: PC, sync-read IMEM driver, tagged instruction FIFO, redirect flush
module instruction_prefetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    IMEM_AW     = 10,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_base,
    input  logic [ADDR_WIDTH-1:0] i_pc_immed,
    output logic [IMEM_AW-1:0]    o_imem_addr,
    input  logic [31:0]           i_imem_dout,
    output logic [31:0]           o_instr,
    output logic [ADDR_WIDTH-1:0] o_instr_pc,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ready
);
    localparam int              PW      = $clog2(QUEUE_DEPTH);
    localparam logic [PW+1:0]   DEPTH_L = (PW+2)'(QUEUE_DEPTH);

    logic [ADDR_WIDTH-1:0] r_f_pc;
    logic [31:0]           r_q_word [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] r_q_pc   [QUEUE_DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW:0]           r_count;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;

    logic                  w_pop;
    logic                  w_write;
    logic                  w_issue;
    logic [PW+1:0]         w_occupancy;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_target_aligned;

    assign o_imem_addr      = r_f_pc[IMEM_AW+1:2];
    assign o_instr_valid    = (r_count != '0);
    assign o_instr          = o_instr_valid ? r_q_word[r_rd_ptr] : 32'd0;
    assign o_instr_pc       = o_instr_valid ? r_q_pc[r_rd_ptr] : '0;

    assign w_pop            = o_instr_valid & i_instr_ready;
    assign w_write          = r_inflight & ~i_redirect & ~i_reset;
    assign w_target         = i_redirect_base + ADDR_WIDTH'(4) + i_pc_immed;
    assign w_target_aligned = w_target & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    // Reserve a slot for the word already in flight so a return can never overflow.
    assign w_occupancy = {1'b0, r_count} + {{(PW+1){1'b0}}, r_inflight}
                       - {{(PW+1){1'b0}}, w_pop};
    assign w_issue     = ~i_reset & ~i_redirect & (w_occupancy < DEPTH_L);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_f_pc        <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (i_redirect) begin
            r_f_pc     <= w_target_aligned;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_f_pc;
                r_f_pc        <= r_f_pc + ADDR_WIDTH'(4);
            end
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + {{PW{1'b0}}, w_write} - {{PW{1'b0}}, w_pop};
        end
    end

    // Queue storage needs no reset: entries are only visible while counted.
    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_q_word[r_wr_ptr] <= i_imem_dout;
            r_q_pc[r_wr_ptr]   <= r_inflight_pc;
        end
    end
endmodule
